// File: rtl/mipi_tx_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : mipi_tx_pattern_gen
// Purpose  : Self-timed RAW10 video source for the MIPI CSI-2 TX pixel port.
//            Emits complete frames (vsync, hsync, valid, 6 pixels per beat).
//            It stands in for the RX-to-TX line-buffer path during bring-up
//            and link test when no camera is attached.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   sys_clk      in   1   clock
//   i_arstn      in   1   asynchronous reset, active-low
//   i_enable     in   1   run request, sampled in IDLE and on the last VFP cycle
//   i_pattern    in   2   0=solid 1=ramp 2=colour bars 3=checkerboard
//   i_solid      in  10   pixel value for the solid pattern
//   o_vsync      out  1   -> mipi_inst2_VSYNC
//   o_hsync      out  1   -> mipi_inst2_HSYNC
//   o_valid      out  1   -> mipi_inst2_VALID
//   o_data       out 64   -> mipi_inst2_DATA, pixel k in [10k+9:10k]
//   o_type       out  6   constant 6'h2B (RAW10)
//   o_hres       out 16   constant HRES
//   o_frame_cnt  out 16   frames started, wraps
//   o_busy       out  1   high whenever the generator is not idle
// Build option:
//   MIPI_PG_FRAME_TAG_EN - when defined, pixel 0 of line 0 / beat 0 carries
//   the low 10 bits of the frame counter.
// ============================================================================
module mipi_tx_pattern_gen #(
  parameter int HRES       = 1920,  // multiple of 48
  parameter int VRES       = 1080,
  parameter int VSYNC_CYC  = 16,
  parameter int VBP_CYC    = 64,
  parameter int HSYNC_CYC  = 4,
  parameter int HS2DE_CYC  = 8,
  parameter int HBLANK_CYC = 40,
  parameter int VFP_CYC    = 64
) (
  input  logic        sys_clk,
  input  logic        i_arstn,
  input  logic        i_enable,
  input  logic [1:0]  i_pattern,
  input  logic [9:0]  i_solid,
  output logic        o_vsync,
  output logic        o_hsync,
  output logic        o_valid,
  output logic [63:0] o_data,
  output logic [5:0]  o_type,
  output logic [15:0] o_hres,
  output logic [15:0] o_frame_cnt,
  output logic        o_busy
);

  // Terminal counts for the per-state cycle counter.
  localparam logic [15:0] VS_LAST    = 16'(VSYNC_CYC - 1);
  localparam logic [15:0] VBP_LAST   = 16'(VBP_CYC - 1);
  localparam logic [15:0] HS_LAST    = 16'(HSYNC_CYC - 1);
  localparam logic [15:0] HS2DE_LAST = 16'(HS2DE_CYC - 1);
  localparam logic [15:0] BEAT_LAST  = 16'(HRES / 6 - 1);
  localparam logic [15:0] HBLK_LAST  = 16'(HBLANK_CYC - 1);
  localparam logic [15:0] VFP_LAST   = 16'(VFP_CYC - 1);
  localparam logic [15:0] LINE_LAST  = 16'(VRES - 1);
  // One colour bar is HRES/8 pixels = HRES/48 beats.
  localparam logic [15:0] BAR_LAST   = 16'(HRES / 48 - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VS     = 3'd1,
    ST_VBP    = 3'd2,
    ST_HS     = 3'd3,
    ST_HS2DE  = 3'd4,
    ST_ACTIVE = 3'd5,
    ST_HBLK   = 3'd6,
    ST_VFP    = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;        // cycles in state; beat index in ACTIVE
  logic [15:0] line_q, line_d;
  logic [2:0]  bar_q, bar_d;        // colour bar index of the current beat
  logic [15:0] barcnt_q, barcnt_d;  // beat position inside the current bar
  logic [15:0] frame_q, frame_d;
  logic [1:0]  pat_q, pat_d;
  logic [9:0]  solid_q, solid_d;
  logic        start_frame;

  logic        vsync_q, hsync_q, valid_q, busy_q;
  logic [63:0] data_q, data_d;
  logic [9:0]  xbase;

  // --------------------------------------------------------------------------
  // Pixel value for one pixel; x is only needed modulo 1024.
  // --------------------------------------------------------------------------
  function automatic logic [9:0] f_pixel(input logic [1:0] pat,
                                         input logic [9:0] solid,
                                         input logic [9:0] x,
                                         input logic [2:0] bar,
                                         input logic       y6);
    logic [9:0] v;
    case (pat)
      2'd0:    v = solid;
      2'd1:    v = x;
      2'd2:    v = {bar, bar, bar, bar[0]};
      default: v = (x[6] ^ y6) ? 10'h3FF : 10'h000;
    endcase
    return v;
  endfunction

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 16'd1;
    line_d      = line_q;
    bar_d       = bar_q;
    barcnt_d    = barcnt_q;
    frame_d     = frame_q;
    pat_d       = pat_q;
    solid_d     = solid_q;
    start_frame = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (i_enable) begin
          state_d     = ST_VS;
          start_frame = 1'b1;
        end
      end
      ST_VS: begin
        if (cnt_q == VS_LAST) begin
          state_d = ST_VBP;
          cnt_d   = '0;
        end
      end
      ST_VBP: begin
        if (cnt_q == VBP_LAST) begin
          state_d = ST_HS;
          cnt_d   = '0;
          line_d  = '0;
        end
      end
      ST_HS: begin
        if (cnt_q == HS_LAST) begin
          state_d = ST_HS2DE;
          cnt_d   = '0;
        end
      end
      ST_HS2DE: begin
        if (cnt_q == HS2DE_LAST) begin
          state_d  = ST_ACTIVE;
          cnt_d    = '0;
          bar_d    = '0;
          barcnt_d = '0;
        end
      end
      ST_ACTIVE: begin
        if (cnt_q == BEAT_LAST) begin
          state_d = ST_HBLK;
          cnt_d   = '0;
        end else if (barcnt_q == BAR_LAST) begin
          // Bar boundary: step the bar index instead of dividing x.
          barcnt_d = '0;
          bar_d    = bar_q + 3'd1;
        end else begin
          barcnt_d = barcnt_q + 16'd1;
        end
      end
      ST_HBLK: begin
        if (cnt_q == HBLK_LAST) begin
          cnt_d = '0;
          if (line_q == LINE_LAST) begin
            state_d = ST_VFP;
          end else begin
            state_d = ST_HS;
            line_d  = line_q + 16'd1;
          end
        end
      end
      ST_VFP: begin
        if (cnt_q == VFP_LAST) begin
          cnt_d = '0;
          if (i_enable) begin
            state_d     = ST_VS;
            start_frame = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Pattern selection is frozen for the whole frame.
    if (start_frame) begin
      frame_d = frame_q + 16'd1;
      pat_d   = i_pattern;
      solid_d = i_solid;
    end
  end

  // --------------------------------------------------------------------------
  // Pixel data for the beat about to be presented. Zero outside ACTIVE.
  // --------------------------------------------------------------------------
  always_comb begin
    data_d = '0;
    // x of pixel 0 = 6 * beat, kept modulo 1024.
    xbase  = {cnt_d[7:0], 2'b00} + {cnt_d[8:0], 1'b0};
    if (state_d == ST_ACTIVE) begin
      for (int k = 0; k < 6; k++) begin
        data_d[10*k +: 10] = f_pixel(pat_q, solid_q, xbase + 10'(k),
                                     bar_d, line_q[6]);
      end
`ifdef MIPI_PG_FRAME_TAG_EN
      if ((line_q == 16'd0) && (cnt_d == 16'd0)) begin
        data_d[9:0] = frame_q[9:0];
      end
`endif
    end
  end

  // --------------------------------------------------------------------------
  // State and output registers. Outputs are registered from the next state so
  // they line up with the state they describe.
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      line_q   <= '0;
      bar_q    <= '0;
      barcnt_q <= '0;
      frame_q  <= '0;
      pat_q    <= '0;
      solid_q  <= '0;
      vsync_q  <= 1'b0;
      hsync_q  <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      line_q   <= line_d;
      bar_q    <= bar_d;
      barcnt_q <= barcnt_d;
      frame_q  <= frame_d;
      pat_q    <= pat_d;
      solid_q  <= solid_d;
      vsync_q  <= (state_d == ST_VS);
      hsync_q  <= (state_d == ST_HS);
      valid_q  <= (state_d == ST_ACTIVE);
      busy_q   <= (state_d != ST_IDLE);
      data_q   <= data_d;
    end
  end

  assign o_vsync     = vsync_q;
  assign o_hsync     = hsync_q;
  assign o_valid     = valid_q;
  assign o_data      = data_q;
  assign o_busy      = busy_q;
  assign o_frame_cnt = frame_q;
  assign o_type      = 6'h2B;
  assign o_hres      = 16'(HRES);

endmodule
`default_nettype wire

// File: tb/tb_mipi_tx_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_mipi_tx_pattern_gen
// Purpose  : Scoreboard bench for mipi_tx_pattern_gen. The stimulus process
//            pushes the full expected per-cycle output trace of every frame
//            it requests; the monitor pops one entry per clock and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mipi_tx_pattern_gen;

  localparam int HRES       = 144;
  localparam int VRES       = 130;
  localparam int VSYNC_CYC  = 2;
  localparam int VBP_CYC    = 3;
  localparam int HSYNC_CYC  = 2;
  localparam int HS2DE_CYC  = 3;
  localparam int HBLANK_CYC = 4;
  localparam int VFP_CYC    = 5;
  localparam int FRAME_LEN  = VSYNC_CYC + VBP_CYC + VFP_CYC +
                              VRES * (HSYNC_CYC + HS2DE_CYC + HRES / 6 + HBLANK_CYC);

  logic        sys_clk;
  logic        i_arstn;
  logic        i_enable;
  logic [1:0]  i_pattern;
  logic [9:0]  i_solid;
  logic        o_vsync, o_hsync, o_valid, o_busy;
  logic [63:0] o_data;
  logic [5:0]  o_type;
  logic [15:0] o_hres;
  logic [15:0] o_frame_cnt;

  mipi_tx_pattern_gen #(
    .HRES(HRES), .VRES(VRES), .VSYNC_CYC(VSYNC_CYC), .VBP_CYC(VBP_CYC),
    .HSYNC_CYC(HSYNC_CYC), .HS2DE_CYC(HS2DE_CYC), .HBLANK_CYC(HBLANK_CYC),
    .VFP_CYC(VFP_CYC)
  ) dut (
    .sys_clk    (sys_clk),
    .i_arstn    (i_arstn),
    .i_enable   (i_enable),
    .i_pattern  (i_pattern),
    .i_solid    (i_solid),
    .o_vsync    (o_vsync),
    .o_hsync    (o_hsync),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_type     (o_type),
    .o_hres     (o_hres),
    .o_frame_cnt(o_frame_cnt),
    .o_busy     (o_busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic        vs;
    logic        hs;
    logic        val;
    logic        busy;
    logic [63:0] data;
    logic [15:0] fc;
  } exp_t;

  exp_t        q[$];
  logic [15:0] fc_model;
  logic [15:0] idle_fc;
  logic        exp_reset;
  int          checks;
  int          errors;

  // --------------------------------------------------------------------------
  // Reference model: pixel value straight from the pattern definitions.
  // --------------------------------------------------------------------------
  function automatic logic [9:0] ref_pix(input logic [1:0] pat, input logic [9:0] solid,
                                         input int x, input int y);
    int b;
    case (pat)
      2'd0: return solid;
      2'd1: return 10'(x % 1024);
      2'd2: begin
        b = x / (HRES / 8);
        return {3'(b), 3'(b), 3'(b), 1'(b % 2)};
      end
      default: return ((((x / 64) % 2) ^ ((y / 64) % 2)) != 0) ? 10'h3FF : 10'h000;
    endcase
  endfunction

  task automatic push(input logic vs, input logic hs, input logic val, input logic [63:0] d);
    exp_t e;
    e.vs   = vs;
    e.hs   = hs;
    e.val  = val;
    e.busy = 1'b1;
    e.data = d;
    e.fc   = fc_model;
    q.push_back(e);
  endtask

  // Expected cycle-by-cycle trace of one whole frame.
  task automatic push_frame(input logic [1:0] pat, input logic [9:0] solid);
    logic [63:0] d;
    fc_model = fc_model + 16'd1;
    repeat (VSYNC_CYC) push(1'b1, 1'b0, 1'b0, 64'd0);
    repeat (VBP_CYC)   push(1'b0, 1'b0, 1'b0, 64'd0);
    for (int y = 0; y < VRES; y++) begin
      repeat (HSYNC_CYC) push(1'b0, 1'b1, 1'b0, 64'd0);
      repeat (HS2DE_CYC) push(1'b0, 1'b0, 1'b0, 64'd0);
      for (int bt = 0; bt < HRES / 6; bt++) begin
        d = '0;
        for (int k = 0; k < 6; k++) d[10*k +: 10] = ref_pix(pat, solid, 6 * bt + k, y);
`ifdef MIPI_PG_FRAME_TAG_EN
        if (y == 0 && bt == 0) d[9:0] = fc_model[9:0];
`endif
        push(1'b0, 1'b0, 1'b1, d);
      end
      repeat (HBLANK_CYC) push(1'b0, 1'b0, 1'b0, 64'd0);
    end
    repeat (VFP_CYC) push(1'b0, 1'b0, 1'b0, 64'd0);
  endtask

  // --------------------------------------------------------------------------
  // Monitor: one comparison per clock, sampled on the falling edge.
  // --------------------------------------------------------------------------
  always @(negedge sys_clk) begin
    exp_t e;
    exp_t a;
    if (exp_reset) begin
      q.delete();
      idle_fc = 16'd0;
      e       = '0;
    end else if (q.size() > 0) begin
      e       = q.pop_front();
      idle_fc = e.fc;
    end else begin
      e    = '0;
      e.fc = idle_fc;
    end
    a.vs   = o_vsync;
    a.hs   = o_hsync;
    a.val  = o_valid;
    a.busy = o_busy;
    a.data = o_data;
    a.fc   = o_frame_cnt;
    checks++;
    if (a !== e || o_type !== 6'h2B || o_hres !== 16'(HRES)) begin
      errors++;
      $display("FAIL trace t=%0t got vs=%0b hs=%0b val=%0b busy=%0b data=%h fc=%0d type=%h hres=%0d, required vs=%0b hs=%0b val=%0b busy=%0b data=%h fc=%0d type=2b hres=%0d",
               $time, a.vs, a.hs, a.val, a.busy, a.data, a.fc, o_type, o_hres,
               e.vs, e.hs, e.val, e.busy, e.data, e.fc, HRES);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (all input changes happen just after a falling edge)
  // --------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      #1;
    end
  endtask

  task automatic wait_q_le(input int n, input int bound);
    int cyc;
    cyc = 0;
    while (q.size() > n) begin
      step(1);
      cyc++;
      if (cyc > bound) begin
        $display("FAIL timeout waiting for scoreboard depth %0d, depth now %0d", n, q.size());
        $fatal(1, "timeout");
      end
    end
  endtask

  // Keep i_enable high for n frames, then drop it mid-way through the last.
  task automatic run_held(input int n, input int first_pat, input bit rnd);
    logic [1:0] p;
    for (int f = 0; f < n; f++) begin
      p         = rnd ? 2'($urandom_range(0, 3)) : 2'((first_pat + f) % 4);
      i_pattern = p;
      i_solid   = 10'($urandom);
      i_enable  = 1'b1;
      push_frame(p, i_solid);
      wait_q_le(FRAME_LEN - 10, 2 * FRAME_LEN + 100);
    end
    wait_q_le(FRAME_LEN / 2, FRAME_LEN);
    i_enable  = 1'b0;
    i_pattern = 2'($urandom_range(0, 3));
    i_solid   = 10'($urandom);
    wait_q_le(0, FRAME_LEN + 50);
    step(20);
  endtask

  initial begin
    int cyc;
    checks    = 0;
    errors    = 0;
    fc_model  = 16'd0;
    idle_fc   = 16'd0;
    exp_reset = 1'b1;
    i_arstn   = 1'b1;
    i_enable  = 1'b0;
    i_pattern = 2'd0;
    i_solid   = 10'd0;
    #1 i_arstn = 1'b0;
    step(4);
    i_arstn   = 1'b1;
    exp_reset = 1'b0;
    step(5);

    // Single-cycle enable pulse, solid 0x155: exactly one frame.
    i_pattern = 2'd0;
    i_solid   = 10'h155;
    i_enable  = 1'b1;
    push_frame(2'd0, 10'h155);
    step(1);
    i_enable  = 1'b0;
    i_pattern = 2'd1;
    i_solid   = 10'($urandom);
    wait_q_le(0, FRAME_LEN + 50);
    step(10);

    // Back-to-back frames: ramp, colour bars, checkerboard.
    run_held(3, 1, 1'b0);
    // Randomised patterns and solid values.
    run_held(2, 0, 1'b1);

    // Asynchronous reset in the middle of an active line.
    i_pattern = 2'($urandom_range(0, 3));
    i_solid   = 10'($urandom);
    i_enable  = 1'b1;
    push_frame(i_pattern, i_solid);
    step(1);
    i_enable = 1'b0;
    cyc = 0;
    while (!(o_valid && q.size() < FRAME_LEN - 300)) begin
      step(1);
      cyc++;
      if (cyc > FRAME_LEN) begin
        $display("FAIL timeout waiting for active line before reset");
        $fatal(1, "timeout");
      end
    end
    @(posedge sys_clk);
    #1;
    i_arstn   = 1'b0;
    exp_reset = 1'b1;
    fc_model  = 16'd0;
    step(3);
    i_arstn   = 1'b1;
    exp_reset = 1'b0;
    step(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
